// File: rtl/io_clk_config_arbiter.sv
// Purpose : round-robin arbiter sharing the IO clock generator config port among
//           REQ_COUNT requesters, with per-channel ownership locks.
// Latency : grant edge A -> write enable in cycle A+1 -> rsp_valid in cycle A+3;
//           next grant at edge A+4 (max one transaction per 4 cycles).
// Backpressure: one transaction in flight; req_ready is low outside IDLE. clk_en=0
//           freezes the FSM/tables and forces the write enables low.
//
// Ports
//   sys_clk, async_rst      clock (rising edge), async active-high reset
//   clk_en                  global advance enable
//   req_valid/req_ready     per-requester handshake, req_ready is a one-hot grant
//   req_op/req_addr/req_data per-requester command (op codes below)
//   rsp_valid/rsp_data/rsp_err  one-cycle response to the granted requester
//   ConfigurationAddr, ConfigWriteEnUpper/Lower, ConfigInput, ConfigOutput
//                           clock generator config port (read-back is combinational)
module io_clk_config_arbiter #(
    parameter int REQ_COUNT  = 4,
    parameter int CLK_COUNT  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                                           sys_clk,
    input  logic                                           async_rst,
    input  logic                                           clk_en,
    input  logic [REQ_COUNT-1:0]                           req_valid,
    output logic [REQ_COUNT-1:0]                           req_ready,
    input  logic [REQ_COUNT-1:0][2:0]                      req_op,
    input  logic [REQ_COUNT-1:0][$clog2(CLK_COUNT)-1:0]    req_addr,
    input  logic [REQ_COUNT-1:0][DATA_WIDTH-1:0]           req_data,
    output logic [REQ_COUNT-1:0]                           rsp_valid,
    output logic [DATA_WIDTH-1:0]                          rsp_data,
    output logic                                           rsp_err,
    output logic [$clog2(CLK_COUNT)-1:0]                   ConfigurationAddr,
    output logic                                           ConfigWriteEnUpper,
    output logic                                           ConfigWriteEnLower,
    output logic [DATA_WIDTH-1:0]                          ConfigInput,
    input  logic [DATA_WIDTH-1:0]                          ConfigOutput
);

    localparam int IW = $clog2(REQ_COUNT);
    localparam int AW = $clog2(CLK_COUNT);

    localparam logic [2:0] OP_RD   = 3'b000;
    localparam logic [2:0] OP_WRL  = 3'b001;
    localparam logic [2:0] OP_WRH  = 3'b010;
    localparam logic [2:0] OP_WRA  = 3'b011;
    localparam logic [2:0] OP_CLM  = 3'b100;
    localparam logic [2:0] OP_REL  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   rr_q, rr_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [2:0]                      op_q, op_d;
    logic [AW-1:0]                   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]           data_q, data_d;
    logic                            err_q, err_d;
    logic [DATA_WIDTH-1:0]           rsp_data_q, rsp_data_d;
    logic [CLK_COUNT-1:0]            owned_q, owned_d;
    logic [CLK_COUNT-1:0][IW-1:0]    owner_q, owner_d;

    // Grant search: first valid requester at or after the rr pointer.
    logic                            gnt_found;
    logic [IW-1:0]                   gnt_idx;
    logic [IW:0]                     cand;
    logic [IW:0]                     rr_nxt;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            cand = {1'b0, rr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(REQ_COUNT)) begin
                cand = cand - (IW+1)'(REQ_COUNT);
            end
            if (!gnt_found && req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
        rr_nxt = {1'b0, gnt_idx} + (IW+1)'(1);
        if (rr_nxt >= (IW+1)'(REQ_COUNT)) begin
            rr_nxt = '0;
        end
    end

    // Ownership check for the latched transaction.
    logic other_owned, self_owned, err_c;

    always_comb begin
        other_owned = owned_q[addr_q] && (owner_q[addr_q] != idx_q);
        self_owned  = owned_q[addr_q] && (owner_q[addr_q] == idx_q);
        case (op_q)
            OP_RD:                  err_c = 1'b0;
            OP_WRL, OP_WRH, OP_WRA: err_c = other_owned;
            OP_CLM:                 err_c = other_owned;
            OP_REL:                 err_c = !self_owned;
            default:                err_c = 1'b1;   // reserved ops
        endcase
    end

    always_comb begin
        state_d            = state_q;
        rr_d               = rr_q;
        idx_d              = idx_q;
        op_d               = op_q;
        addr_d             = addr_q;
        data_d             = data_q;
        err_d              = err_q;
        rsp_data_d         = rsp_data_q;
        owned_d            = owned_q;
        owner_d            = owner_q;
        req_ready          = '0;
        rsp_valid          = '0;
        rsp_err            = 1'b0;
        ConfigWriteEnUpper = 1'b0;
        ConfigWriteEnLower = 1'b0;

        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        // Gated by reset so every output reads 0 while reset is held.
                        req_ready[gnt_idx] = !async_rst;
                        idx_d   = gnt_idx;
                        op_d    = req_op[gnt_idx];
                        addr_d  = req_addr[gnt_idx];
                        data_d  = req_data[gnt_idx];
                        rr_d    = rr_nxt[IW-1:0];
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!err_c) begin
                        ConfigWriteEnLower = (op_q == OP_WRL) || (op_q == OP_WRA);
                        ConfigWriteEnUpper = (op_q == OP_WRH) || (op_q == OP_WRA);
                        if (op_q == OP_CLM) begin
                            owned_d[addr_q] = 1'b1;
                            owner_d[addr_q] = idx_q;
                        end
                        if (op_q == OP_REL) begin
                            owned_d[addr_q] = 1'b0;
                        end
                    end
                    err_d   = err_c;
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // The write landed on the previous edge, so this is post-write data.
                    rsp_data_d = ConfigOutput;
                    state_d    = ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid[idx_q] = 1'b1;
                    rsp_err          = err_q;
                    state_d          = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ConfigurationAddr = addr_q;
    assign ConfigInput       = data_q;
    assign rsp_data          = rsp_data_q;

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            idx_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            owned_q    <= '0;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
            owned_q    <= owned_d;
            owner_q    <= owner_d;
        end
    end

endmodule

// File: tb/tb_io_clk_config_arbiter.sv
// Purpose : self-checking bench for io_clk_config_arbiter with a clock generator model.
// Latency : checks grant->enable->response timing of A / A+1 / A+3.
// Backpressure: one requester at a time except the round-robin and post-reset cases.
module tb_io_clk_config_arbiter;

    localparam logic [2:0] OP_RD  = 3'b000;
    localparam logic [2:0] OP_WRL = 3'b001;
    localparam logic [2:0] OP_WRH = 3'b010;
    localparam logic [2:0] OP_WRA = 3'b011;
    localparam logic [2:0] OP_CLM = 3'b100;
    localparam logic [2:0] OP_REL = 3'b101;
    localparam logic [2:0] OP_RSV = 3'b110;

    logic             sys_clk = 1'b0;
    logic             async_rst;
    logic             clk_en;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][2:0]  req_op;
    logic [3:0][1:0]  req_addr;
    logic [3:0][15:0] req_data;
    logic [3:0]       rsp_valid;
    logic [15:0]      rsp_data;
    logic             rsp_err;
    logic [1:0]       cfg_addr;
    logic             we_u, we_l;
    logic [15:0]      cfg_in;
    logic [15:0]      cfg_out;

    io_clk_config_arbiter dut (
        .sys_clk            (sys_clk),
        .async_rst          (async_rst),
        .clk_en             (clk_en),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_addr           (req_addr),
        .req_data           (req_data),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_err            (rsp_err),
        .ConfigurationAddr  (cfg_addr),
        .ConfigWriteEnUpper (we_u),
        .ConfigWriteEnLower (we_l),
        .ConfigInput        (cfg_in),
        .ConfigOutput       (cfg_out)
    );

    always #5 sys_clk = ~sys_clk;

    // Clock generator config registers with byte-lane writes.
    logic [15:0] cg_reg [4];
    int          we_pulses = 0;

    initial begin
        for (int i = 0; i < 4; i++) cg_reg[i] = 16'h0000;
    end

    always @(posedge sys_clk) begin
        if (we_u) cg_reg[cfg_addr][15:8] <= cfg_in[15:8];
        if (we_l) cg_reg[cfg_addr][7:0]  <= cfg_in[7:0];
        if (we_u || we_l) we_pulses <= we_pulses + 1;
    end

    assign cfg_out = cg_reg[cfg_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard of expected responses.
    typedef struct {
        int          r;
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge sys_clk) begin
        if (rsp_valid != 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_who",  32'(rsp_valid), 32'(1 << mon_e.r));
                chk("rsp_data", 32'(rsp_data),  32'(mon_e.d));
                chk("rsp_err",  32'(rsp_err),   32'(mon_e.e));
            end
        end
    end

    function automatic exp_t mk_exp(input int r, input logic [15:0] d, input logic e);
        exp_t x;
        x.r = r; x.d = d; x.e = e;
        return x;
    endfunction

    task automatic drive(input int r, input logic [2:0] op, input logic [1:0] a,
                         input logic [15:0] d);
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_addr[r]  = a;
        req_data[r]  = d;
    endtask

    typedef struct {
        int          r;
        logic [2:0]  op;
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] ed;
        logic        ee;
        logic [1:0]  we;   // {upper, lower}
    } vec_t;

    vec_t vt [18];

    task automatic txn(input vec_t v);
        int n;
        sb_q.push_back(mk_exp(v.r, v.ed, v.ee));
        @(negedge sys_clk);
        drive(v.r, v.op, v.a, v.d);
        #1;
        n = 0;
        while (req_ready[v.r] !== 1'b1 && n < 20) begin
            @(negedge sys_clk); #1;
            n++;
        end
        if (n >= 20) begin
            chk("grant_timeout", 32'(n), 32'h0);
            req_valid[v.r] = 1'b0;
            sb_q.delete(sb_q.size() - 1);
            return;
        end
        chk("ready_onehot", 32'(req_ready), 32'(1 << v.r));
        @(posedge sys_clk); #1;                    // cycle A+1
        req_valid[v.r] = 1'b0;
        chk("we_A1", 32'({we_u, we_l}), 32'(v.we));
        chk("addr_A1", 32'(cfg_addr), 32'(v.a));
        if (v.we != 2'b00) chk("cfg_in_A1", 32'(cfg_in), 32'(v.d));
        @(posedge sys_clk); #1;                    // cycle A+2
        chk("we_A2", 32'({we_u, we_l}), 32'h0);
        @(posedge sys_clk); #1;                    // cycle A+3
        chk("rsp_A3", 32'(rsp_valid), 32'(1 << v.r));
        @(posedge sys_clk); #1;                    // cycle A+4, back in IDLE
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, cyc, last, p0;

        vt[0]  = '{0, OP_WRA, 2'd2, 16'h8123, 16'h8123, 1'b0, 2'b11};
        vt[1]  = '{0, OP_RD,  2'd2, 16'h0000, 16'h8123, 1'b0, 2'b00};
        vt[2]  = '{1, OP_WRA, 2'd0, 16'h4400, 16'h4400, 1'b0, 2'b11};
        vt[3]  = '{1, OP_WRL, 2'd0, 16'h00AB, 16'h44AB, 1'b0, 2'b01};
        vt[4]  = '{1, OP_RD,  2'd0, 16'h0000, 16'h44AB, 1'b0, 2'b00};
        vt[5]  = '{2, OP_CLM, 2'd1, 16'h0000, 16'h0000, 1'b0, 2'b00};
        vt[6]  = '{3, OP_WRA, 2'd1, 16'h0001, 16'h0000, 1'b1, 2'b00};
        vt[7]  = '{3, OP_RD,  2'd1, 16'h0000, 16'h0000, 1'b0, 2'b00};
        vt[8]  = '{3, OP_REL, 2'd1, 16'h0000, 16'h0000, 1'b1, 2'b00};
        vt[9]  = '{2, OP_REL, 2'd1, 16'h0000, 16'h0000, 1'b0, 2'b00};
        vt[10] = '{3, OP_WRA, 2'd1, 16'h0001, 16'h0001, 1'b0, 2'b11};
        vt[11] = '{0, OP_WRH, 2'd3, 16'hBEEF, 16'hBE00, 1'b0, 2'b10};
        vt[12] = '{0, OP_RSV, 2'd3, 16'h1234, 16'hBE00, 1'b1, 2'b00};
        vt[13] = '{3, OP_CLM, 2'd3, 16'h0000, 16'hBE00, 1'b0, 2'b00};
        vt[14] = '{3, OP_CLM, 2'd3, 16'h0000, 16'hBE00, 1'b0, 2'b00};
        vt[15] = '{0, OP_CLM, 2'd3, 16'h0000, 16'hBE00, 1'b1, 2'b00};
        vt[16] = '{0, OP_WRL, 2'd3, 16'h0011, 16'hBE00, 1'b1, 2'b00};
        vt[17] = '{3, OP_WRL, 2'd3, 16'h0011, 16'hBE11, 1'b0, 2'b01};

        // Reset state, with every requester asking.
        async_rst = 1'b1;
        clk_en    = 1'b1;
        req_valid = 4'hF;
        req_op    = '0;
        req_addr  = '0;
        req_data  = '0;
        #12;
        chk("rst_ready",    32'(req_ready), 32'h0);
        chk("rst_rsp",      32'(rsp_valid), 32'h0);
        chk("rst_we",       32'({we_u, we_l}), 32'h0);
        chk("rst_addr",     32'(cfg_addr), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_err",  32'(rsp_err), 32'h0);
        req_valid = 4'h0;
        @(negedge sys_clk);
        async_rst = 1'b0;

        // Table-driven single transactions (writes, lanes, ownership, reserved op).
        for (int i = 0; i < 18; i++) txn(vt[i]);

        // Round robin: all four valid with pointer back at 0.
        for (int k = 0; k < 5; k++) sb_q.push_back(mk_exp(k % 4, 16'h44AB, 1'b0));
        @(negedge sys_clk);
        for (int r = 0; r < 4; r++) drive(r, OP_RD, 2'd0, 16'h0000);
        #1;
        g = 0; cyc = 0; last = 0;
        while (g < 5 && cyc < 60) begin
            if (req_ready != 4'b0000) begin
                chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
                if (g > 0) chk("rr_spacing", 32'(cyc - last), 32'd4);
                last = cyc;
                g++;
                if (g == 5) begin
                    @(posedge sys_clk); #1;
                    req_valid = 4'h0;
                end
            end
            if (g < 5) begin
                @(negedge sys_clk); #1;
                cyc++;
            end
        end
        if (g < 5) begin
            chk("rr_timeout", 32'(g), 32'd5);
            req_valid = 4'h0;
        end
        repeat (5) @(posedge sys_clk);
        #1;

        // Reset asserted in ISSUE: enables drop at once, no response, no write.
        @(negedge sys_clk);
        drive(1, OP_WRA, 2'd0, 16'h1234);
        #1;
        chk("abort_ready", 32'(req_ready), 32'h2);
        @(posedge sys_clk); #1;
        req_valid[1] = 1'b0;
        chk("abort_we_before", 32'({we_u, we_l}), 32'h3);
        p0 = we_pulses;
        #2;
        async_rst = 1'b1;
        #1;
        chk("abort_we_drop", 32'({we_u, we_l}), 32'h0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        async_rst = 1'b0;
        chk("abort_no_write", 32'(we_pulses - p0), 32'h0);

        // After reset: pointer is 0 and owners are clear (ch3 was owned by req3).
        sb_q.push_back(mk_exp(0, 16'hBE77, 1'b0));
        sb_q.push_back(mk_exp(2, 16'h44AB, 1'b0));
        drive(0, OP_WRL, 2'd3, 16'h0077);
        drive(2, OP_RD,  2'd0, 16'h0000);
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        @(posedge sys_clk); #1;
        req_valid[0] = 1'b0;
        chk("post_rst_we", 32'({we_u, we_l}), 32'h1);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("post_rst_rsp0", 32'(rsp_valid), 32'h1);
        @(posedge sys_clk); #1;
        chk("post_rst_grant2", 32'(req_ready), 32'h4);
        @(posedge sys_clk); #1;
        req_valid[2] = 1'b0;
        chk("post_rst_we2", 32'({we_u, we_l}), 32'h0);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("post_rst_rsp2", 32'(rsp_valid), 32'h4);
        @(posedge sys_clk); #1;

        // clk_en low for 3 cycles during ISSUE.
        sb_q.push_back(mk_exp(1, 16'h5523, 1'b0));
        @(negedge sys_clk);
        drive(1, OP_WRH, 2'd2, 16'h5500);
        #1;
        chk("cen_ready", 32'(req_ready), 32'h2);
        @(posedge sys_clk); #1;
        req_valid[1] = 1'b0;
        clk_en = 1'b0;
        p0 = we_pulses;
        #1;
        chk("cen_we_low1", 32'({we_u, we_l}), 32'h0);
        @(posedge sys_clk); #1;
        chk("cen_we_low2", 32'({we_u, we_l}), 32'h0);
        @(posedge sys_clk); #1;
        chk("cen_we_low3", 32'({we_u, we_l}), 32'h0);
        @(posedge sys_clk); #1;
        chk("cen_no_write", 32'(we_pulses - p0), 32'h0);
        clk_en = 1'b1;
        #1;
        chk("cen_we_high", 32'({we_u, we_l}), 32'h2);
        chk("cen_no_rsp", 32'(rsp_valid), 32'h0);
        @(posedge sys_clk); #1;
        chk("cen_one_write", 32'(we_pulses - p0), 32'h1);
        chk("cen_rsp_early", 32'(rsp_valid), 32'h0);
        @(posedge sys_clk); #1;
        chk("cen_rsp", 32'(rsp_valid), 32'h2);
        @(posedge sys_clk); #1;
        chk("cen_single_write", 32'(we_pulses - p0), 32'h1);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
